// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit's memory port and mem_responder.
// The master drives the request fields. The slave returns a one-cycle ready strobe with data and an error flag.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              m_req;
    logic              m_rw_;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              m_err;
    logic              m_busy;

    modport master (
        output m_req,
        output m_rw_,
        output m_addr,
        output m_wdata,
        input  m_rdata,
        input  m_ready,
        input  m_err,
        input  m_busy
    );

    modport slave (
        input  m_req,
        input  m_rw_,
        input  m_addr,
        input  m_wdata,
        output m_rdata,
        output m_ready,
        output m_err,
        output m_busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM behind a req/ready handshake, with a fixed number of wait states.
// Accesses at or beyond DEPTH are flagged with m_err.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 200,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_l;
    logic              rw_l;
    logic [DATA_W-1:0] wdata_l;
    logic              ready;
    logic              err;
    logic [DATA_W-1:0] rdata;

    logic              accept;
    logic              go_resp;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_rw;
    logic [DATA_W-1:0] cur_wdata;
    logic              in_range;

    // With zero wait states the accepting edge is also the edge entering RESP,
    // so the transaction must be taken straight from the bus rather than the latches.
    always_comb begin
        accept    = (state == IDLE) && bus.m_req;
        go_resp   = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
        cur_addr  = (state == IDLE) ? bus.m_addr  : addr_l;
        cur_rw    = (state == IDLE) ? bus.m_rw_   : rw_l;
        cur_wdata = (state == IDLE) ? bus.m_wdata : wdata_l;
        in_range  = 32'(cur_addr) < DEPTH;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_l  <= '0;
            rw_l    <= 1'b0;
            wdata_l <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_l  <= bus.m_addr;
                        rw_l    <= bus.m_rw_;
                        wdata_l <= bus.m_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                ready <= 1'b1;
                err   <= !in_range;
                rdata <= (in_range && cur_rw) ? mem[cur_addr] : '0;
            end
        end
    end

    // Storage is deliberately not reset; gating on reset keeps an aborted write from landing.
    always_ff @(posedge clock) begin
        if (reset && go_resp && in_range && !cur_rw) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

    assign bus.m_ready = ready;
    assign bus.m_err   = err;
    assign bus.m_rdata = rdata;
    assign bus.m_busy  = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        req [2];
    logic        rw  [2];
    logic [7:0]  addr[2];
    logic [15:0] wd  [2];
    logic [15:0] rd  [2];
    logic        rdy [2];
    logic        er  [2];
    logic        bsy [2];

    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

    assign bus0.m_req   = req[0];
    assign bus0.m_rw_   = rw[0];
    assign bus0.m_addr  = addr[0];
    assign bus0.m_wdata = wd[0];
    assign rd[0]  = bus0.m_rdata;
    assign rdy[0] = bus0.m_ready;
    assign er[0]  = bus0.m_err;
    assign bsy[0] = bus0.m_busy;
    assign bus1.m_req   = req[1];
    assign bus1.m_rw_   = rw[1];
    assign bus1.m_addr  = addr[1];
    assign bus1.m_wdata = wd[1];
    assign rd[1]  = bus1.m_rdata;
    assign rdy[1] = bus1.m_ready;
    assign er[1]  = bus1.m_err;
    assign bsy[1] = bus1.m_busy;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(0)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request, waits for ready (busy must stay high meanwhile), then
    // checks that ready is a single-cycle strobe and busy drops with it.
    task automatic txn(input int w, input logic r, input logic [7:0] a, input logic [15:0] d,
                       output logic [15:0] rdata, output logic e, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        req[w] = 1'b1; rw[w] = r; addr[w] = a; wd[w] = d;
        for (int n = 1; n <= 40 && !got; n++) begin
            tick();
            lat = n;
            chk("busy during txn", 32'(bsy[w]), 32'd1);
            if (rdy[w]) got = 1'b1;
        end
        chk("ready seen", 32'(got), 32'd1);
        rdata = rd[w];
        e = er[w];
        req[w] = 1'b0;
        tick();
        chk("ready single cycle", 32'(rdy[w]), 32'd0);
        chk("busy after resp", 32'(bsy[w]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic        e;
        int          lat;
        logic        got;

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rw[i] = 1'b1; addr[i] = 8'd0; wd[i] = 16'd0;
        end

        vecs[0] = '{1'b0, 8'd10,  16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 8'd10,  16'h0000, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 8'd200, 16'hFFFF, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 8'd200, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 8'd199, 16'h5A5A, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 8'd199, 16'h0000, 16'h5A5A, 1'b0};
        vecs[6] = '{1'b1, 8'd10,  16'h0000, 16'h1234, 1'b0};
        vecs[7] = '{1'b1, 8'd5,   16'h0000, 16'h1111, 1'b0};
        vecs[8] = '{1'b1, 8'd4,   16'h0000, 16'h0044, 1'b0};
        vecs[9] = '{1'b1, 8'd3,   16'h0000, 16'h00AA, 1'b0};

        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", 32'(bsy[i]), 32'd0);
            chk("reset ready", 32'(rdy[i]), 32'd0);
            chk("reset err", 32'(er[i]), 32'd0);
            chk("reset rdata", 32'(rd[i]), 32'd0);
        end
        reset = 1'b1;
        tick();

        // Reset aborts a write in WAIT: RAM[5] must keep 0x1111.
        txn(0, 1'b0, 8'd5, 16'h1111, r, e, lat);
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'd5; wd[0] = 16'hBEEF;
        tick();
        tick();
        chk("busy mid wait", 32'(bsy[0]), 32'd1);
        req[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort busy", 32'(bsy[0]), 32'd0);
        chk("abort ready", 32'(rdy[0]), 32'd0);
        #1 reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("no resp after abort", 32'(rdy[0]), 32'd0);
            chk("idle after abort", 32'(bsy[0]), 32'd0);
        end

        // Bus changes during WAIT must not affect the read at 3 nor write 4.
        txn(0, 1'b0, 8'd3, 16'h00AA, r, e, lat);
        txn(0, 1'b0, 8'd4, 16'h0044, r, e, lat);
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'd3; wd[0] = 16'h0000;
        tick();
        addr[0] = 8'd4; rw[0] = 1'b0; wd[0] = 16'hDEAD;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            if (rdy[0]) got = 1'b1;
            else tick();
        end
        chk("unstable ready seen", 32'(got), 32'd1);
        chk("unstable rdata", 32'(rd[0]), 32'h00AA);
        chk("unstable err", 32'(er[0]), 32'd0);
        req[0] = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 10; i++) begin
            txn(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, r, e, lat);
            chk($sformatf("vec%0d rdata", i), 32'(r), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
        end

        // Zero-wait instance: continuous m_req gives a ready every second cycle.
        txn(1, 1'b0, 8'd0, 16'h0A0A, r, e, lat);
        chk("w0 write latency", 32'(lat), 32'd1);
        txn(1, 1'b0, 8'd1, 16'h0B0B, r, e, lat);
        req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 8'd0;
        tick();
        chk("b2b ready0", 32'(rdy[1]), 32'd1);
        chk("b2b rdata0", 32'(rd[1]), 32'h0A0A);
        addr[1] = 8'd1;
        tick();
        chk("b2b gap", 32'(rdy[1]), 32'd0);
        chk("b2b gap rdata", 32'(rd[1]), 32'd0);
        tick();
        chk("b2b ready1", 32'(rdy[1]), 32'd1);
        chk("b2b rdata1", 32'(rd[1]), 32'h0B0B);
        chk("b2b err1", 32'(er[1]), 32'd0);
        req[1] = 1'b0;
        tick();
        chk("b2b tail0", 32'(rdy[1]), 32'd0);
        tick();
        chk("b2b tail1", 32'(rdy[1]), 32'd0);
        chk("b2b idle", 32'(bsy[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
